// File: rtl/branch_pkg.sv
//----------------------------------------------------------------------------
// Module : branch_pkg
// Shared types and constants for the branch controller.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

package branch_pkg;

  localparam int PC_W_DEF      = 10;
  localparam int LUT_IDX_W_DEF = 5;
  localparam int PROG_W_DEF    = 2;

  typedef enum logic [2:0] {
    NONE   = 3'd0,
    ALWAYS = 3'd1,
    IFZ    = 3'd2,
    IFC    = 3'd3,
    HALT   = 3'd4
  } br_op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_RUN    = 3'd3,
    ST_HALT   = 3'd4
  } bc_state_t;

  localparam logic [PC_W_DEF-1:0] ENTRY [4] = '{
    10'd0, 10'd128, 10'd256, 10'd384
  };

endpackage : branch_pkg

`default_nettype wire

// File: rtl/branch_lut.sv
//----------------------------------------------------------------------------
// Module : branch_lut
// Combinational ROM mapping a branch index to a two's-complement PC offset.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module branch_lut
  import branch_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int LUT_IDX_W = LUT_IDX_W_DEF
) (
  input  logic [LUT_IDX_W-1:0] idx,
  output logic [PC_W-1:0]      offset
);

  // Negative entries are backward branches; unlisted indices give offset 0.
  always_comb begin
    offset = '0;
    case (idx)
      LUT_IDX_W'(0):  offset = PC_W'(10);
      LUT_IDX_W'(1):  offset = PC_W'(5);
      LUT_IDX_W'(2):  offset = PC_W'(-3);
      LUT_IDX_W'(3):  offset = PC_W'(2);
      LUT_IDX_W'(4):  offset = PC_W'(-1);
      LUT_IDX_W'(5):  offset = PC_W'(16);
      LUT_IDX_W'(6):  offset = PC_W'(-16);
      LUT_IDX_W'(7):  offset = PC_W'(64);
      LUT_IDX_W'(8):  offset = PC_W'(-64);
      LUT_IDX_W'(9):  offset = PC_W'(32);
      LUT_IDX_W'(10): offset = PC_W'(-32);
      LUT_IDX_W'(11): offset = PC_W'(3);
      LUT_IDX_W'(12): offset = PC_W'(-8);
      LUT_IDX_W'(13): offset = PC_W'(8);
      LUT_IDX_W'(14): offset = PC_W'(128);
      LUT_IDX_W'(15): offset = PC_W'(-128);
      default:        offset = '0;
    endcase
  end

endmodule : branch_lut

`default_nettype wire

// File: rtl/branch_ctrl.sv
//----------------------------------------------------------------------------
// Module : branch_ctrl
// Launch sequencer, flag latch and branch resolver driving the PC Jen/Jump port.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module branch_ctrl
  import branch_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int LUT_IDX_W = LUT_IDX_W_DEF,
  parameter int PROG_W    = PROG_W_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [PROG_W-1:0]    ProgSel,
  input  logic [PC_W-1:0]      PC,
  input  logic [2:0]           BrOp,
  input  logic [LUT_IDX_W-1:0] BrIdx,
  input  logic                 FlagWe,
  input  logic                 AluZero,
  input  logic                 AluCarry,
  output logic                 Jen,
  output logic [PC_W-1:0]      Jump,
  output logic                 Done
);

  bc_state_t         state;
  bc_state_t         next_state;
  logic              zero_flag;
  logic              carry_flag;
  logic [PROG_W-1:0] prog_sel_reg;
  logic [PC_W-1:0]   lut_offset;
  logic [PC_W-1:0]   entry_pc;

  branch_lut #(
    .PC_W      (PC_W),
    .LUT_IDX_W (LUT_IDX_W)
  ) u_lut (
    .idx    (BrIdx),
    .offset (lut_offset)
  );

  assign entry_pc = PC_W'(ENTRY[prog_sel_reg]);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= ST_IDLE;
      zero_flag    <= 1'b0;
      carry_flag   <= 1'b0;
      prog_sel_reg <= '0;
    end else begin
      state <= next_state;
      if (FlagWe) begin
        zero_flag  <= AluZero;
        carry_flag <= AluCarry;
      end
      if (state == ST_ARM && !Start) begin
        prog_sel_reg <= ProgSel;
      end
    end
  end

  // Default output is hold (Jen=1, Jump=0): the PC adds zero and stays put.
  always_comb begin
    next_state = state;
    Jen        = 1'b1;
    Jump       = '0;
    case (state)
      ST_IDLE: begin
        if (Start) next_state = ST_ARM;
      end
      ST_ARM: begin
        if (!Start) next_state = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        Jump       = entry_pc - PC;
        next_state = ST_RUN;
      end
      ST_RUN: begin
        case (BrOp)
          ALWAYS: Jump = lut_offset;
          IFZ: begin
            Jen  = zero_flag;
            Jump = zero_flag ? lut_offset : '0;
          end
          IFC: begin
            Jen  = carry_flag;
            Jump = carry_flag ? lut_offset : '0;
          end
          HALT:    next_state = ST_HALT;
          default: Jen = 1'b0;
        endcase
      end
      ST_HALT: begin
        if (Start) next_state = ST_ARM;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign Done = (state == ST_HALT);

endmodule : branch_ctrl

`default_nettype wire

// File: tb/tb_branch_ctrl.sv
//----------------------------------------------------------------------------
// Module : tb_branch_ctrl
// Scoreboard bench for branch_ctrl: expected outputs queued per driven cycle.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_branch_ctrl;
  import branch_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] prog_sel;
  logic [9:0] pc;
  logic [2:0] br_op;
  logic [4:0] br_idx;
  logic       flag_we;
  logic       alu_zero;
  logic       alu_carry;
  logic       jen;
  logic [9:0] jump;
  logic       done;

  typedef struct {
    string      tag;
    logic       jen;
    logic [9:0] jump;
    logic       chk_jump;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  branch_ctrl #(
    .PC_W      (10),
    .LUT_IDX_W (5),
    .PROG_W    (2)
  ) dut (
    .Clk      (clk),
    .Reset    (rst),
    .Start    (start),
    .ProgSel  (prog_sel),
    .PC       (pc),
    .BrOp     (br_op),
    .BrIdx    (br_idx),
    .FlagWe   (flag_we),
    .AluZero  (alu_zero),
    .AluCarry (alu_carry),
    .Jen      (jen),
    .Jump     (jump),
    .Done     (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge; optionally queue the
  // outputs expected while this cycle's inputs are applied.
  task automatic drive(input string tag, input logic r, input logic s, input logic [1:0] ps,
                       input logic [9:0] p, input logic [2:0] op, input logic [4:0] idx,
                       input logic fwe, input logic z, input logic c, input logic push,
                       input logic ejen, input logic [9:0] ejump, input logic echk,
                       input logic edone);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; start = s; prog_sel = ps; pc = p; br_op = op; br_idx = idx;
    flag_we = fwe; alu_zero = z; alu_carry = c;
    if (push) begin
      e.tag = tag; e.jen = ejen; e.jump = ejump; e.chk_jump = echk; e.done = edone;
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_eq({e.tag, "_jen"}, {31'd0, jen}, {31'd0, e.jen});
      check_eq({e.tag, "_done"}, {31'd0, done}, {31'd0, e.done});
      if (e.chk_jump) check_eq({e.tag, "_jump"}, {22'd0, jump}, {22'd0, e.jump});
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; prog_sel = '0; pc = '0; br_op = NONE; br_idx = '0;
    flag_we = 1'b0; alu_zero = 1'b0; alu_carry = 1'b0;

    //     tag          rst st ps pc      op      idx fwe z  c  push jen jump     chk done
    drive("reset",      1, 0, 0, 10'd0,  NONE,   0, 0, 0, 0, 0,   0, 10'd0,   0, 0);
    drive("idle0",      0, 0, 0, 10'd0,  NONE,   0, 0, 0, 0, 1,   1, 10'd0,   1, 0);
    drive("idle1",      0, 0, 0, 10'd0,  NONE,   0, 0, 0, 0, 1,   1, 10'd0,   1, 0);
    drive("start_idle", 0, 1, 2, 10'd0,  NONE,   0, 0, 0, 0, 1,   1, 10'd0,   1, 0);
    drive("arm",        0, 0, 2, 10'd0,  NONE,   0, 0, 0, 0, 1,   1, 10'd0,   1, 0);
    drive("launch2",    0, 0, 0, 10'd0,  NONE,   0, 0, 0, 0, 1,   1, 10'd256, 1, 0);
    drive("always0",    0, 0, 0, 10'd1,  ALWAYS, 0, 0, 0, 0, 1,   1, 10'd10,  1, 0);
    drive("none",       0, 0, 0, 10'd11, NONE,   0, 0, 0, 0, 1,   0, 10'd0,   0, 0);
    drive("ifz_same",   0, 0, 0, 10'd12, IFZ,    1, 1, 1, 0, 1,   0, 10'd0,   0, 0);
    drive("ifz_taken",  0, 0, 0, 10'd13, IFZ,    1, 0, 0, 0, 1,   1, 10'd5,   1, 0);
    drive("ifc_not",    0, 0, 0, 10'd18, IFC,    0, 0, 0, 0, 1,   0, 10'd0,   0, 0);
    drive("always_neg", 0, 0, 0, 10'd19, ALWAYS, 2, 0, 0, 0, 1,   1, 10'h3FD, 1, 0);
    drive("halt_op",    0, 0, 0, 10'd16, HALT,   0, 0, 0, 0, 1,   1, 10'd0,   1, 0);
    drive("halted0",    0, 0, 0, 10'd16, NONE,   0, 0, 0, 0, 1,   1, 10'd0,   1, 1);
    drive("halted1",    0, 0, 0, 10'd16, ALWAYS, 0, 0, 0, 0, 1,   1, 10'd0,   1, 1);
    drive("halt_start", 0, 1, 0, 10'd16, NONE,   0, 0, 0, 0, 1,   1, 10'd0,   1, 1);
    drive("rearm",      0, 0, 3, 10'd16, NONE,   0, 0, 0, 0, 1,   1, 10'd0,   1, 0);
    drive("relaunch3",  0, 0, 0, 10'd16, NONE,   0, 0, 0, 0, 1,   1, 10'h170, 1, 0);
    drive("flags_set",  0, 0, 0, 10'd384,NONE,   0, 1, 1, 1, 1,   0, 10'd0,   0, 0);
    drive("ifc_taken",  0, 0, 0, 10'd385,IFC,    1, 0, 0, 0, 1,   1, 10'd5,   1, 0);
    drive("rst_in_run", 1, 1, 0, 10'd390,ALWAYS, 0, 0, 0, 0, 1,   1, 10'd10,  1, 0);
    drive("post_rst",   0, 0, 0, 10'd400,IFZ,    0, 0, 0, 0, 1,   1, 10'd0,   1, 0);
    drive("start2",     0, 1, 0, 10'd0,  NONE,   0, 0, 0, 0, 1,   1, 10'd0,   1, 0);
    drive("arm2",       0, 0, 0, 10'd0,  NONE,   0, 0, 0, 0, 1,   1, 10'd0,   1, 0);
    drive("launch0",    0, 0, 0, 10'd0,  NONE,   0, 0, 0, 0, 1,   1, 10'd0,   1, 0);
    drive("ifz_cleared",0, 0, 0, 10'd1,  IFZ,    0, 0, 0, 0, 1,   0, 10'd0,   0, 0);
    drive("run_start",  0, 1, 0, 10'd2,  ALWAYS, 0, 0, 0, 0, 1,   1, 10'd10,  1, 0);
    drive("run_start2", 0, 1, 0, 10'd12, NONE,   0, 0, 0, 0, 1,   0, 10'd0,   0, 0);
    drive("undef_op",   0, 0, 0, 10'd13, 3'd5,   0, 0, 0, 0, 1,   0, 10'd0,   0, 0);
    drive("undef_op7",  0, 0, 0, 10'd14, 3'd7,   0, 0, 0, 0, 1,   0, 10'd0,   0, 0);

    @(posedge clk);
    @(posedge clk);
    check_eq("sb_drain", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_branch_ctrl

`default_nettype wire
